// File: rtl/axi4_command_arbiter_if.sv
// Bundle of requester, divider-command and ID-FIFO signals around the command arbiter.
// slave: arbiter view; master: the surrounding requesters/divider/data path.
interface axi4_command_arbiter_if #(
    parameter int NumRequesters      = 2,
    parameter int AddressWidth       = 32,
    parameter int InnerIFLengthWidth = 16,
    parameter int IdWidth            = (NumRequesters > 1) ? $clog2(NumRequesters) : 1
);
    logic [NumRequesters*AddressWidth-1:0]       REQADDR;
    logic [NumRequesters*InnerIFLengthWidth-1:0] REQLEN;
    logic [NumRequesters-1:0]                    REQVALID;
    logic [NumRequesters-1:0]                    REQREADY;
    logic [AddressWidth-1:0]                     SRCADDR;
    logic [InnerIFLengthWidth-1:0]               SRCLEN;
    logic                                        SRCVALID;
    logic                                        SRCREADY;
    logic [IdWidth-1:0]                          GRANTID;
    logic [IdWidth-1:0]                          OUTID;
    logic                                        OUTIDVALID;
    logic                                        OUTIDPOP;

    modport slave (
        input  REQADDR, REQLEN, REQVALID, SRCREADY, OUTIDPOP,
        output REQREADY, SRCADDR, SRCLEN, SRCVALID, GRANTID, OUTID, OUTIDVALID
    );

    modport master (
        output REQADDR, REQLEN, REQVALID, SRCREADY, OUTIDPOP,
        input  REQREADY, SRCADDR, SRCLEN, SRCVALID, GRANTID, OUTID, OUTIDVALID
    );
endinterface

// File: rtl/axi4_command_arbiter.sv
// Round-robin arbiter sharing one command divider among several requesters;
// issued requester IDs are queued so the data path can steer beats back.
module axi4_command_arbiter #(
    parameter int NumRequesters      = 2,
    parameter int AddressWidth       = 32,
    parameter int InnerIFLengthWidth = 16,
    parameter int IdFifoDepth        = 4
) (
    input logic                   ACLK,
    input logic                   ARESETN,
    axi4_command_arbiter_if.slave bus
);
    localparam int IdWidth  = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;
    localparam int PtrWidth = $clog2(IdFifoDepth);
    localparam int CntWidth = PtrWidth + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                        state_q, state_d;
    logic [IdWidth-1:0]            last_q;
    logic [IdWidth-1:0]            winner;
    logic                          found;
    logic                          grant_en;
    logic                          push;
    logic                          pop;
    logic [AddressWidth-1:0]       win_addr;
    logic [InnerIFLengthWidth-1:0] win_len;
    logic [AddressWidth-1:0]       src_addr_q;
    logic [InnerIFLengthWidth-1:0] src_len_q;
    logic [IdWidth-1:0]            grant_q;
    logic [IdWidth-1:0]            fifo_mem [IdFifoDepth];
    logic [PtrWidth-1:0]           wr_ptr, rd_ptr;
    logic [CntWidth-1:0]           count;

    // Scan upward from the requester after the last grant, wrapping around.
    always_comb begin : arbitrate
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NumRequesters; k++) begin
            idx = (int'(last_q) + k) % NumRequesters;
            if (!found && bus.REQVALID[idx]) begin
                found  = 1'b1;
                winner = IdWidth'(idx);
            end
        end
    end

    assign win_addr = bus.REQADDR[int'(winner)*AddressWidth +: AddressWidth];
    assign win_len  = bus.REQLEN[int'(winner)*InnerIFLengthWidth +: InnerIFLengthWidth];

    // ARESETN gates the strobe so no accept escapes while reset is held.
    assign grant_en = ARESETN && (state_q == IDLE) && found && (count < CntWidth'(IdFifoDepth));
    assign push     = (state_q == ISSUE) && bus.SRCREADY;
    assign pop      = bus.OUTIDPOP && (count != '0);

    always_comb begin
        state_d      = state_q;
        bus.REQREADY = '0;
        case (state_q)
            IDLE: begin
                if (grant_en) begin
                    bus.REQREADY[winner] = 1'b1;
                    if (win_len != '0) state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.SRCREADY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= IDLE;
            last_q     <= IdWidth'(NumRequesters - 1);
            src_addr_q <= '0;
            src_len_q  <= '0;
            grant_q    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            state_q <= state_d;
            if (grant_en) begin
                src_addr_q <= win_addr;
                src_len_q  <= win_len;
                grant_q    <= winner;
                last_q     <= winner;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PtrWidth{1'b0}}, push} - {{PtrWidth{1'b0}}, pop};
        end
    end

    always_ff @(posedge ACLK) begin
        if (push) fifo_mem[wr_ptr] <= grant_q;
    end

    assign bus.SRCVALID   = (state_q == ISSUE);
    assign bus.SRCADDR    = src_addr_q;
    assign bus.SRCLEN     = src_len_q;
    assign bus.GRANTID    = grant_q;
    assign bus.OUTID      = fifo_mem[rd_ptr];
    assign bus.OUTIDVALID = (count != '0);
endmodule

// File: tb/tb_axi4_command_arbiter.sv
// Directed bench for axi4_command_arbiter with a scoreboard of expected issued IDs.
module tb_axi4_command_arbiter;
    localparam int NR    = 4;
    localparam int AW    = 32;
    localparam int LW    = 16;
    localparam int DEPTH = 4;
    localparam int IW    = 2;

    logic ACLK = 1'b0;
    logic ARESETN;
    always #5 ACLK = ~ACLK;

    axi4_command_arbiter_if #(
        .NumRequesters(NR), .AddressWidth(AW), .InnerIFLengthWidth(LW), .IdWidth(IW)
    ) bus ();

    axi4_command_arbiter #(
        .NumRequesters(NR), .AddressWidth(AW), .InnerIFLengthWidth(LW), .IdFifoDepth(DEPTH)
    ) dut (
        .ACLK(ACLK),
        .ARESETN(ARESETN),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int exp_id[$];
    int lastg;
    int k;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag);
        int e;
        check({tag, "_valid"}, bus.OUTIDVALID, 1);
        if (exp_id.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, bus.OUTID);
        end else begin
            e = exp_id.pop_front();
            check(tag, bus.OUTID, e);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
        bus.REQADDR[i*AW +: AW] = a;
        bus.REQLEN[i*LW +: LW]  = l;
    endtask

    initial begin
        ARESETN       = 1'b0;
        bus.REQVALID  = '0;
        bus.REQADDR   = '0;
        bus.REQLEN    = '0;
        bus.SRCREADY  = 1'b0;
        bus.OUTIDPOP  = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, AW'(32'h100 * (i + 1)), LW'(i + 1));
        tick();
        tick();
        check("rst_srcvalid", bus.SRCVALID, 0);
        check("rst_reqready", bus.REQREADY, 0);
        check("rst_outidvalid", bus.OUTIDVALID, 0);
        check("rst_grantid", bus.GRANTID, 0);
        check("rst_srcaddr", bus.SRCADDR, 0);
        check("rst_srclen", bus.SRCLEN, 0);
        ARESETN = 1'b1;

        // Round-robin with all requesters valid until the FIFO fills
        bus.REQVALID = '1;
        bus.SRCREADY = 1'b1;
        settle();
        for (int n = 0; n < 4; n++) begin
            check("rr_grant", bus.REQREADY, 64'(1 << n));
            exp_id.push_back(n);
            tick(); settle();
            check("rr_srcvalid", bus.SRCVALID, 1);
            check("rr_grantid", bus.GRANTID, n);
            check("rr_srcaddr", bus.SRCADDR, 32'h100 * (n + 1));
            tick(); settle();
        end
        check("rr_full_block", bus.REQREADY, 0);
        check("rr_full_idle", bus.SRCVALID, 0);
        tick(); settle();
        check("rr_full_block2", bus.REQREADY, 0);
        bus.OUTIDPOP = 1'b1;
        settle();
        check_head("rr_pop_a");
        check("rr_block_during_pop", bus.REQREADY, 0);
        tick();
        bus.OUTIDPOP = 1'b0;
        settle();
        check("rr_grant_after_pop", bus.REQREADY, 4'b0001);
        exp_id.push_back(0);
        tick(); settle();
        check("rr_grantid_wrap", bus.GRANTID, 0);
        tick(); settle();
        check("rr_full_block3", bus.REQREADY, 0);
        bus.OUTIDPOP = 1'b1;
        settle();
        check_head("rr_pop_b");
        tick();
        bus.OUTIDPOP = 1'b0;
        settle();
        check("rr_grant_next", bus.REQREADY, 4'b0010);
        exp_id.push_back(1);
        tick();
        bus.REQVALID = '0;
        settle();
        check("rr_grantid_next", bus.GRANTID, 1);
        tick(); settle();
        check("rr_back_idle", bus.SRCVALID, 0);
        bus.OUTIDPOP = 1'b1;
        for (int n = 0; n < 4; n++) begin
            settle();
            check_head("rr_drain");
            tick();
        end
        bus.OUTIDPOP = 1'b0;
        settle();
        check("rr_drained", bus.OUTIDVALID, 0);

        // Zero-length command from requester 0 is accepted and dropped
        set_req(0, 32'h5000, 16'd0);
        bus.REQVALID = 4'b0011;
        settle();
        check("zl_grant0", bus.REQREADY, 4'b0001);
        tick();
        bus.REQVALID = 4'b0010;
        settle();
        check("zl_no_srcvalid", bus.SRCVALID, 0);
        check("zl_no_push", bus.OUTIDVALID, 0);
        check("zl_next_grant", bus.REQREADY, 4'b0010);
        exp_id.push_back(1);
        tick();
        bus.REQVALID = '0;
        settle();
        check("zl_srcvalid", bus.SRCVALID, 1);
        check("zl_grantid", bus.GRANTID, 1);
        tick(); settle();
        bus.OUTIDPOP = 1'b1;
        settle();
        check_head("zl_pop");
        tick();
        bus.OUTIDPOP = 1'b0;
        settle();
        check("zl_empty", bus.OUTIDVALID, 0);
        set_req(0, 32'h100, 16'd1);

        // Single request held off by the divider for three cycles
        set_req(1, 32'h1000, 16'd40);
        bus.REQVALID = 4'b0010;
        bus.SRCREADY = 1'b0;
        settle();
        check("sr_grant", bus.REQREADY, 4'b0010);
        exp_id.push_back(1);
        tick();
        bus.REQVALID = '0;
        settle();
        check("sr_ready_pulse", bus.REQREADY, 0);
        for (int c = 0; c < 4; c++) begin
            check("sr_srcvalid", bus.SRCVALID, 1);
            check("sr_srcaddr", bus.SRCADDR, 32'h1000);
            check("sr_srclen", bus.SRCLEN, 40);
            check("sr_grantid", bus.GRANTID, 1);
            if (c == 3) bus.SRCREADY = 1'b1;
            tick(); settle();
        end
        check("sr_srcvalid_low", bus.SRCVALID, 0);
        bus.OUTIDPOP = 1'b1;
        settle();
        check_head("sr_outid");
        tick();
        bus.OUTIDPOP = 1'b0;
        settle();
        check("sr_empty", bus.OUTIDVALID, 0);
        set_req(1, 32'h200, 16'd2);

        // Six grants with a pop in every push cycle: pointer wrap and push+pop at count 1
        lastg = 1;
        bus.REQVALID = '1;
        settle();
        for (int n = 0; n < 6; n++) begin
            k = (lastg + 1) % NR;
            check("wr_grant", bus.REQREADY, 64'(1 << k));
            if (n > 0) check("wr_valid_kept", bus.OUTIDVALID, 1);
            exp_id.push_back(k);
            lastg = k;
            tick();
            if (n == 5) bus.REQVALID = '0;
            bus.OUTIDPOP = (n > 0);
            settle();
            if (n > 0) check_head("wr_pop");
            check("wr_srcvalid", bus.SRCVALID, 1);
            check("wr_grantid", bus.GRANTID, k);
            tick();
            bus.OUTIDPOP = 1'b0;
            settle();
        end
        bus.OUTIDPOP = 1'b1;
        settle();
        check_head("wr_last");
        tick();
        bus.OUTIDPOP = 1'b0;
        settle();
        check("wr_empty", bus.OUTIDVALID, 0);

        // Pop on an empty FIFO must not disturb count or pointers
        bus.OUTIDPOP = 1'b1;
        settle();
        check("pe_valid0", bus.OUTIDVALID, 0);
        tick();
        tick();
        bus.OUTIDPOP = 1'b0;
        settle();
        check("pe_valid1", bus.OUTIDVALID, 0);
        bus.REQVALID = 4'b0100;
        settle();
        check("pe_grant", bus.REQREADY, 4'b0100);
        exp_id.push_back(2);
        tick();
        bus.REQVALID = '0;
        settle();
        check("pe_grantid", bus.GRANTID, 2);
        tick(); settle();
        check_head("pe_outid");

        // Reset while a command is in Issue
        bus.REQVALID = 4'b1000;
        bus.SRCREADY = 1'b0;
        settle();
        check("ri_grant", bus.REQREADY, 4'b1000);
        tick(); settle();
        check("ri_srcvalid", bus.SRCVALID, 1);
        check("ri_grantid", bus.GRANTID, 3);
        ARESETN = 1'b0;
        bus.REQVALID = 4'b1001;
        settle();
        check("ri_srcvalid_rst", bus.SRCVALID, 0);
        check("ri_reqready_rst", bus.REQREADY, 0);
        check("ri_outidvalid_rst", bus.OUTIDVALID, 0);
        check("ri_grantid_rst", bus.GRANTID, 0);
        exp_id.delete();
        tick();
        ARESETN = 1'b1;
        settle();
        check("ri_prio0", bus.REQREADY, 4'b0001);
        exp_id.push_back(0);
        bus.SRCREADY = 1'b1;
        tick();
        bus.REQVALID = '0;
        settle();
        check("ri_srcvalid", bus.SRCVALID, 1);
        check("ri_srcaddr", bus.SRCADDR, 32'h100);
        tick(); settle();
        bus.OUTIDPOP = 1'b1;
        settle();
        check_head("ri_outid");
        tick();
        bus.OUTIDPOP = 1'b0;
        settle();
        check("ri_empty", bus.OUTIDVALID, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
